// File: rtl/adg732_bus_monitor_if.sv
// Raw ADG732 parallel control bus as seen at the monitor's pins.
// Everything here is asynchronous to the monitor's clock.
interface adg732_bus_monitor_if;
    logic       cs_n_in;
    logic       wr_n_in;
    logic       en_n_in;
    logic [4:0] addr_in;

    modport master (output cs_n_in, output wr_n_in, output en_n_in, output addr_in);
    modport slave  (input  cs_n_in, input  wr_n_in, input  en_n_in, input  addr_in);
endinterface

// File: rtl/adg732_bus_monitor.sv
// Receiving end of the ADG732 control bus: synchronises the pins, decodes writes the way the
// part does (latch on WR_n rising with CS_n low), and flags protocol violations.
module adg732_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WR_LOW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adg732_bus_monitor_if.slave   bus,
    input  logic                  err_clr,
    output logic [4:0]            ch,
    output logic                  sw_on,
    output logic                  wr_stb,
    output logic [7:0]            wr_cnt,
    output logic [2:0]            err,
    output logic [1:0]            fsm_state
);
    localparam int LCW = $clog2(MIN_WR_LOW + 1);
    localparam logic [LCW-1:0] LC_MAX = LCW'(MIN_WR_LOW);

    typedef enum logic [1:0] {IDLE = 2'd0, SEL = 2'd1, WRITE = 2'd2} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, wr_sync, en_sync;
    logic [4:0]             addr_sync [SYNC_STAGES];
    logic                   cs_n_s, wr_n_s, en_n_s;
    logic [4:0]             addr_s;

    state_t         state;
    logic [LCW-1:0] lowcnt;
    logic [4:0]     a_hold;
    logic [2:0]     err_set;
    logic           accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '1;
            wr_sync <= '1;
            en_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) addr_sync[i] <= '0;
        end else begin
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n_in};
            wr_sync      <= {wr_sync[SYNC_STAGES-2:0], bus.wr_n_in};
            en_sync      <= {en_sync[SYNC_STAGES-2:0], bus.en_n_in};
            addr_sync[0] <= bus.addr_in;
            for (int i = 1; i < SYNC_STAGES; i++) addr_sync[i] <= addr_sync[i-1];
        end
    end

    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    assign wr_n_s    = wr_sync[SYNC_STAGES-1];
    assign en_n_s    = en_sync[SYNC_STAGES-1];
    assign addr_s    = addr_sync[SYNC_STAGES-1];
    assign fsm_state = state;

    // Errors and write acceptance are decided only while a WR_n low phase is being tracked.
    always_comb begin
        err_set = '0;
        accept  = 1'b0;
        if (state == WRITE) begin
            if (!wr_n_s) begin
                if (addr_s != a_hold) err_set[2] = 1'b1;
                if (cs_n_s)           err_set[1] = 1'b1;
            end else if (lowcnt >= LC_MAX) begin
                accept = 1'b1;
            end else begin
                err_set[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lowcnt <= '0;
            a_hold <= '0;
            ch     <= '0;
            sw_on  <= 1'b0;
            wr_stb <= 1'b0;
            wr_cnt <= '0;
            err    <= '0;
        end else begin
            sw_on  <= ~en_n_s;
            wr_stb <= accept;
            // A new error in the clearing cycle survives the clear.
            err    <= (err & ~{3{err_clr}}) | err_set;
            if (accept) begin
                ch     <= a_hold;
                wr_cnt <= wr_cnt + 8'd1;
            end
            case (state)
                IDLE: if (!cs_n_s) state <= SEL;
                SEL: begin
                    if (cs_n_s) begin
                        state <= IDLE;
                    end else if (!wr_n_s) begin
                        state  <= WRITE;
                        lowcnt <= LCW'(1);
                        a_hold <= addr_s;
                    end
                end
                WRITE: begin
                    if (!wr_n_s) begin
                        if (lowcnt < LC_MAX) lowcnt <= lowcnt + LCW'(1);
                        a_hold <= addr_s;
                        if (cs_n_s) state <= IDLE;
                    end else begin
                        state <= cs_n_s ? IDLE : SEL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
